// File: rtl/fp_pkg.sv
// Shared types, default widths and constant helpers for the pipelined FP adder.
package fp_pkg;

  localparam int unsigned DEF_EXPW  = 8;
  localparam int unsigned DEF_FRACW = 23;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fpclass_t;

  typedef struct packed {
    logic special;
    logic sign;
    logic eff_sub;
  } s1_ctl_t;

  typedef struct packed {
    logic special;
    logic sign;
  } s2_ctl_t;

  function automatic int unsigned bias(input int unsigned expw);
    return (32'd1 << (expw - 32'd1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
  function automatic logic [63:0] qnan(input int unsigned expw, input int unsigned fracw);
    logic [63:0] r;
    r = ((64'd1 << expw) - 64'd1) << fracw;
    r = r | (64'd1 << (fracw - 32'd1));
    return r;
  endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; all-zero input returns WIDTH.
module lzc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] d,
  output logic [CW-1:0]    cnt_c
);

  // Higher set bits override lower ones, leaving the MSB-most position.
  always_comb begin
    cnt_c = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) cnt_c = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpaddsub_pipe.sv
// 3-stage pipelined floating-point add/subtract (align, add, normalise/round)
// with valid/ready streaming and a single global advance enable.
module fpaddsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXPW  = DEF_EXPW,
  parameter int unsigned FRACW = DEF_FRACW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXPW+FRACW:0] a,
  input  logic [EXPW+FRACW:0] b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXPW+FRACW:0] s,
  output logic                ovf,
  output logic                uf
);

  localparam int unsigned W  = 1 + EXPW + FRACW;
  localparam int unsigned MW = FRACW + 4;
  localparam int unsigned EW = EXPW + 2;
  localparam int unsigned LW = $clog2(MW + 1);
  localparam logic [EXPW-1:0]      EONES  = '1;
  localparam logic [W-1:0]         QNAN   = W'(qnan(EXPW, FRACW));
  localparam logic signed [EW-1:0] EMAX_S = $signed({2'b00, EONES});

  function automatic fpclass_t classify(input logic [EXPW-1:0] e, input logic [FRACW-1:0] f);
    if (e == '0) return FP_ZERO;
    if (e != EONES) return FP_NORM;
    return (f == '0) ? FP_INF : FP_NAN;
  endfunction

  logic en;
  logic v1, v2;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Stage 1: classify, order by magnitude, align Y with guard/round/sticky.
  logic            sa, sb, swap, special_c;
  logic [EXPW-1:0] ea, eb, ex, ey, ediff;
  logic [FRACW-1:0] fa, fb, fx, fy;
  fpclass_t        ca, cb;
  logic [MW-1:0]   ym, yal;
  logic [2*MW-1:0] ysh;
  logic [W-1:0]    spec_c;

  always_comb begin
    sa    = a[W-1];
    sb    = b[W-1] ^ sub;
    ea    = a[W-2:FRACW];
    eb    = b[W-2:FRACW];
    fa    = a[FRACW-1:0];
    fb    = b[FRACW-1:0];
    ca    = classify(ea, fa);
    cb    = classify(eb, fb);
    swap  = {eb, fb} > {ea, fa};
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    fx    = swap ? fb : fa;
    fy    = swap ? fa : fb;
    ediff = ex - ey;
    ym    = {1'b1, fy, 3'b000};
    ysh   = {ym, {MW{1'b0}}} >> ediff;
    yal   = ysh[2*MW-1:MW] | MW'(|ysh[MW-1:0]);
    if (32'(ediff) >= FRACW + 3) yal = MW'(1);

    special_c = (ca != FP_NORM) || (cb != FP_NORM);
    spec_c    = {sa, a[W-2:0]};
    if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_INF && sa != sb))
      spec_c = QNAN;
    else if (ca == FP_INF)
      spec_c = {sa, EONES, {FRACW{1'b0}}};
    else if (cb == FP_INF)
      spec_c = {sb, EONES, {FRACW{1'b0}}};
    else if (ca == FP_ZERO && cb == FP_ZERO)
      spec_c = {sa & sb, {(W-1){1'b0}}};
    else if (ca == FP_ZERO)
      spec_c = {sb, b[W-2:0]};
  end

  s1_ctl_t         s1_ctl;
  logic [W-1:0]    s1_spec;
  logic [EXPW-1:0] s1_ex;
  logic [MW-1:0]   s1_mx, s1_my;

  // Stage 2: magnitude add or subtract; X >= Y so the difference is never negative.
  logic [MW:0] sum_c;
  assign sum_c = s1_ctl.eff_sub ? ({1'b0, s1_mx} - {1'b0, s1_my})
                                : ({1'b0, s1_mx} + {1'b0, s1_my});

  s2_ctl_t         s2_ctl;
  logic [W-1:0]    s2_spec;
  logic [EXPW-1:0] s2_ex;
  logic [MW:0]     s2_sum;

  // Stage 3: normalise, round to nearest even, saturate or flush.
  logic [LW-1:0]    lz;
  logic [MW-1:0]    norm_m;
  logic [EW-1:0]    norm_e, fin_e;
  logic             rnd_up, rc, e_ovf, e_uf;
  logic [FRACW+1:0] rm;
  logic [FRACW-1:0] frac_r;
  logic [W-1:0]     res_c;
  logic             ovf_c, uf_c;

  lzc #(.WIDTH(MW), .CW(LW)) u_lzc (
    .d    (s2_sum[MW-1:0]),
    .cnt_c(lz)
  );

  always_comb begin
    norm_m = '0;
    norm_e = '0;
    if (s2_sum[MW]) begin
      norm_m = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
      norm_e = EW'(s2_ex) + EW'(1);
    end else begin
      norm_m = s2_sum[MW-1:0] << lz;
      norm_e = EW'(s2_ex) - EW'(lz);
    end
    rnd_up = norm_m[2] & (norm_m[3] | norm_m[1] | norm_m[0]);
    rm     = {1'b0, norm_m[MW-1:3]} + (FRACW+2)'(rnd_up);
    rc     = rm[FRACW+1];
    frac_r = rc ? rm[FRACW:1] : rm[FRACW-1:0];
    fin_e  = norm_e + EW'(rc);
    e_ovf  = $signed(fin_e) >= EMAX_S;
    e_uf   = fin_e[EW-1] | (fin_e == '0);

    res_c = {s2_ctl.sign, fin_e[EXPW-1:0], frac_r};
    ovf_c = 1'b0;
    uf_c  = 1'b0;
    if (s2_ctl.special) begin
      res_c = s2_spec;
    end else if (s2_sum == '0) begin
      res_c = '0;
    end else if (e_ovf) begin
      res_c = {s2_ctl.sign, EONES, {FRACW{1'b0}}};
      ovf_c = 1'b1;
    end else if (e_uf) begin
      res_c = {s2_ctl.sign, {(W-1){1'b0}}};
      uf_c  = 1'b1;
    end
  end

  // Valid bits and result registers; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      ovf       <= 1'b0;
      uf        <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        s   <= res_c;
        ovf <= ovf_c;
        uf  <= uf_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      s1_ctl  <= '{special: special_c, sign: (swap ? sb : sa), eff_sub: (sa ^ sb)};
      s1_spec <= spec_c;
      s1_ex   <= ex;
      s1_mx   <= {1'b1, fx, 3'b000};
      s1_my   <= yal;
    end
    if (en && v1) begin
      s2_ctl  <= '{special: s1_ctl.special, sign: s1_ctl.sign};
      s2_spec <= s1_spec;
      s2_ex   <= s1_ex;
      s2_sum  <= sum_c;
    end
  end

endmodule

// File: tb/tb_fpaddsub_pipe.sv
// Self-checking bench for fpaddsub_pipe: directed cases, backpressure, reset, random.
module tb_fpaddsub_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, sub, out_valid, out_ready, ovf, uf;
  logic [31:0] a, b, s;

  int          n_vec = 0;
  int          n_err = 0;
  logic [33:0] expq[$];
  logic [31:0] spec_tbl [0:8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                  32'h7FC00000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000,
                                  32'h00000001};

  always #5 clk = ~clk;

  fpaddsub_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .ovf      (ovf),
    .uf       (uf)
  );

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Exact-value reference: scale both operands to a common integer, sum, then round once.
  function automatic logic [33:0] fp_ref(input logic [31:0] x, input logic [31:0] y, input logic op_sub);
    logic         sx, sy, sr;
    int           ex, ey, p, e;
    logic [299:0] ix, iy, mag, keep, rem, half;
    bit           nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
    sx = x[31];
    sy = y[31] ^ op_sub;
    ex = {24'd0, x[30:23]};
    ey = {24'd0, y[30:23]};
    nan_x  = (ex == 255) && (x[22:0] != 0);
    nan_y  = (ey == 255) && (y[22:0] != 0);
    inf_x  = (ex == 255) && (x[22:0] == 0);
    inf_y  = (ey == 255) && (y[22:0] == 0);
    zero_x = (ex == 0);
    zero_y = (ey == 0);
    if (nan_x || nan_y || (inf_x && inf_y && sx != sy)) return {2'b00, 32'h7FC00000};
    if (inf_x) return {2'b00, sx, 8'hFF, 23'h0};
    if (inf_y) return {2'b00, sy, 8'hFF, 23'h0};
    if (zero_x && zero_y) return {2'b00, sx & sy, 31'h0};
    if (zero_x) return {2'b00, sy, y[30:0]};
    if (zero_y) return {2'b00, x};
    ix = 300'({1'b1, x[22:0]}) << (ex - 1);
    iy = 300'({1'b1, y[22:0]}) << (ey - 1);
    if (sx == sy) begin
      mag = ix + iy; sr = sx;
    end else if (ix >= iy) begin
      mag = ix - iy; sr = sx;
    end else begin
      mag = iy - ix; sr = sy;
    end
    if (mag == 0) return 34'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {2'b01, sr, 31'h0};
    keep = mag;
    if (p > 23) begin
      keep = mag >> (p - 23);
      rem  = mag - (keep << (p - 23));
      half = 300'(1) << (p - 24);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep[24]) begin
        keep = keep >> 1;
        e    = e + 1;
      end
    end
    if (e >= 255) return {2'b10, sr, 8'hFF, 23'h0};
    return {2'b00, sr, 8'(e), keep[22:0]};
  endfunction

  // One clock: drive inputs, check handshake and any presented result, report acceptance.
  task automatic cycle(input logic iv, input logic [31:0] aa, input logic [31:0] bb,
                       input logic ss, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = iv;
    a         = aa;
    b         = bb;
    sub       = ss;
    out_ready = ordy;
    #1;
    check("in_ready", {33'b0, in_ready}, {33'b0, ~out_valid | ordy});
    if (out_valid) begin
      if (expq.size() == 0) check("spurious_out", {33'b0, out_valid}, 34'b0);
      else begin
        check("result", {ovf, uf, s}, expq[0]);
        if (ordy) void'(expq.pop_front());
      end
    end
    acc = iv & (~out_valid | ordy);
  endtask

  task automatic run_one(input logic [31:0] aa, input logic [31:0] bb, input logic ss,
                         input logic [33:0] exp);
    logic acc;
    cycle(1'b1, aa, bb, ss, 1'b1, acc);
    if (acc) expq.push_back(exp);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("lat1", {33'b0, out_valid}, 34'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("lat2", {33'b0, out_valid}, 34'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("lat3", {33'b0, out_valid}, 34'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 20 && expq.size() != 0; t++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("drain", 34'(expq.size()), 34'd0);
  endtask

  task automatic gen(output logic [31:0] aa, output logic [31:0] bb, output logic ss);
    int k;
    k  = int'($urandom_range(0, 3));
    aa = $urandom;
    bb = $urandom;
    ss = 1'($urandom_range(0, 1));
    case (k)
      1: bb = aa ^ 32'($urandom_range(0, 7));
      2: bb[30:23] = aa[30:23] + 8'($urandom_range(0, 60)) - 8'd30;
      3: begin
        aa = spec_tbl[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) == 1) bb = spec_tbl[$urandom_range(0, 8)];
      end
      default: ;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] x, y;
    logic        z;
    int          cyc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {ovf, uf, s}, 34'h0);
    check("reset_valid", {33'b0, out_valid}, 34'd0);
    reset = 1'b0;

    run_one(32'h3F800000, 32'h40000000, 1'b0, {2'b00, 32'h40400000});
    run_one(32'h3F800000, 32'h3F800000, 1'b1, {2'b00, 32'h00000000});
    run_one(32'hC0000000, 32'h3F800000, 1'b0, {2'b00, 32'hBF800000});
    run_one(32'h3F800000, 32'h33800000, 1'b0, {2'b00, 32'h3F800000});
    run_one(32'h3F800000, 32'h34400000, 1'b0, {2'b00, 32'h3F800002});
    run_one(32'h3F800000, 32'h3F7FFFFF, 1'b0, {2'b00, 32'h40000000});
    run_one(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {2'b10, 32'h7F800000});
    run_one(32'h7F800000, 32'hFF800000, 1'b0, {2'b00, 32'h7FC00000});
    run_one(32'h7FC00001, 32'h3F800000, 1'b0, {2'b00, 32'h7FC00000});
    run_one(32'h00800000, 32'h00800001, 1'b1, {2'b01, 32'h80000000});
    run_one(32'h00000000, 32'hC1200000, 1'b1, {2'b00, 32'h41200000});
    run_one(32'h80000000, 32'h80000000, 1'b0, {2'b00, 32'h80000000});
    run_one(32'h80000000, 32'h80000000, 1'b1, {2'b00, 32'h00000000});
    drain();

    // Backpressure: ten back-to-back ops with out_ready low for five cycles mid-stream.
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      gen(x, y, z);
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        cycle(1'b1, x, y, z, !(cyc >= 4 && cyc < 9), acc);
        cyc++;
      end
      check("issue_timeout", {33'b0, acc}, 34'd1);
      if (acc) expq.push_back(fp_ref(x, y, z));
    end
    drain();

    // Reset with three operations in flight: none of them may ever emerge.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3F800000 + 32'(i), 32'h40000000, 1'b0, 1'b1, acc);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    expq.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_valid", {33'b0, out_valid}, 34'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    run_one(32'h40400000, 32'h3F800000, 1'b1, {2'b00, 32'h40000000});
    drain();

    // Random traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      gen(x, y, z);
      cycle($urandom_range(0, 3) != 0, x, y, z, $urandom_range(0, 4) != 0, acc);
      if (acc) expq.push_back(fp_ref(x, y, z));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
